// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: state encoding, bundle types and constants shared by the MEM stage.
package mem_access_stage_pkg;
   localparam int REG_ADDR_W       = 5;
   localparam int DATA_W           = 32;
   localparam int MAX_WAIT_DEFAULT = 15;
   localparam int CNT_W            = 8;
   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
   typedef struct packed {
      logic                  memtoreg;
      logic                  regwrite;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     alu;
      logic [DATA_W-1:0]     data;
   } memwb_t;
   typedef struct packed {
      logic                  we;
      logic                  memtoreg;
      logic                  regwrite;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     alu;
      logic [DATA_W-1:0]     wdata;
   } hold_t;
   function automatic logic [DATA_W-1:0] align_addr(input logic [DATA_W-1:0] a, input int n);
      return a & ~((DATA_W'(1) << n) - DATA_W'(1));
   endfunction
endpackage

// File: rtl/mem_access_stage_memwb.sv
// memwb_reg: MEM/WB pipeline register; a bubble clears the whole bundle.
module memwb_reg
   import mem_access_stage_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_n,
   input  logic   load_i,
   input  logic   bubble_i,
   input  memwb_t d_i,
   output memwb_t q_o
);
   memwb_t q_q;
   always_ff @(posedge clk_i or negedge rst_n)
      if (!rst_n) q_q <= '0;
      else if (load_i) q_q <= bubble_i ? '0 : d_i;
   assign q_o = q_q;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with req/ready data-memory handshake, stall, timeout
// abort and branch resolution; drives the MEM/WB register.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int MAX_WAIT   = MAX_WAIT_DEFAULT,
   parameter int ADDR_ALIGN = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  memread_i,
   input  logic                  memwrite_i,
   input  logic                  branch_i,
   input  logic                  zero_i,
   input  logic                  memtoreg_i,
   input  logic                  RegWrite_i,
   input  logic [DATA_W-1:0]     alu_i,
   input  logic [DATA_W-1:0]     rt_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0]     branch_data_i,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [DATA_W-1:0]     dmem_addr_o,
   output logic [DATA_W-1:0]     dmem_wdata_o,
   input  logic [DATA_W-1:0]     dmem_rdata_i,
   input  logic                  dmem_ready_i,
   output logic                  stall_o,
   output logic                  pcsrc_o,
   output logic [DATA_W-1:0]     branch_target_o,
   output logic                  memtoreg_o,
   output logic                  RegWrite_o,
   output logic [REG_ADDR_W-1:0] rd_addr_o,
   output logic [DATA_W-1:0]     alu_o,
   output logic [DATA_W-1:0]     mem_data_o,
   output logic                  timeout_o
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   hold_t            hold_q, hold_d, in_b, cur;
   logic             timeout_q, timeout_d;
   logic             access, is_wait, abort, bubble;
   memwb_t           memwb_d, memwb_q;

   assign access  = memread_i | memwrite_i;
   assign is_wait = state_q == S_WAIT;
   assign abort   = is_wait & ~dmem_ready_i & (cnt_q == CNT_W'(MAX_WAIT));
   assign in_b    = '{we: memwrite_i, memtoreg: memtoreg_i, regwrite: RegWrite_i,
                      rd: rd_addr_i, alu: alu_i, wdata: rt_i};
   // Upstream may change while stalled, so a waiting access runs from the holding registers
   assign cur     = is_wait ? hold_q : in_b;

   always_ff @(posedge clk_i or negedge rst_n)
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      timeout_d = timeout_q | abort;
      if (!is_wait) begin
         if (access & ~dmem_ready_i) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
            hold_d  = in_b;
         end
      end else if (dmem_ready_i | abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Request and stall are gated by reset so they drop at once, even mid-access
   always_comb begin
      dmem_req_o      = rst_n & (is_wait ? ~abort : access);
      stall_o         = rst_n & ~dmem_ready_i & (is_wait ? ~abort : access);
      dmem_we_o       = cur.we;
      dmem_addr_o     = align_addr(cur.alu, ADDR_ALIGN);
      dmem_wdata_o    = cur.wdata;
      pcsrc_o         = branch_i & zero_i & ~is_wait;
      branch_target_o = branch_data_i;
      bubble          = ~dmem_ready_i & (is_wait | access);
      memwb_d         = '{memtoreg: cur.memtoreg, regwrite: cur.regwrite, rd: cur.rd, alu: cur.alu,
                          data: ((is_wait | access) & ~cur.we) ? dmem_rdata_i : '0};
   end

   memwb_reg u_memwb (
      .clk_i    (clk_i),
      .rst_n    (rst_n),
      .load_i   (1'b1),
      .bubble_i (bubble),
      .d_i      (memwb_d),
      .q_o      (memwb_q)
   );

   assign memtoreg_o = memwb_q.memtoreg;
   assign RegWrite_o = memwb_q.regwrite;
   assign rd_addr_o  = memwb_q.rd;
   assign alu_o      = memwb_q.alu;
   assign mem_data_o = memwb_q.data;
   assign timeout_o  = timeout_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table vectors, directed stall/timeout/reset sequences and randomized
// instructions with random memory latency checked against a transaction-level model.
module tb_mem_access_stage;
   localparam int MW = 4;
   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        memread_i, memwrite_i, branch_i, zero_i, memtoreg_i, RegWrite_i;
   logic [31:0] alu_i, rt_i, branch_data_i, dmem_rdata_i;
   logic [4:0]  rd_addr_i;
   logic        dmem_ready_i;
   logic        dmem_req_o, dmem_we_o, stall_o, pcsrc_o, memtoreg_o, RegWrite_o, timeout_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o, branch_target_o, alu_o, mem_data_o;
   logic [4:0]  rd_addr_o;
   int          checks = 0;
   int          errors = 0;
   bit          model_to = 1'b0;

   typedef struct {
      logic ld, st, br, z, m2r, rw;
      logic [31:0] alu, rt, bd;
      logic [4:0]  rdst;
      int          lat;
   } instr_t;

   typedef struct {
      logic ld, st, br, z, m2r, rw, ready;
      logic [31:0] alu, rt, bd, rdata;
      logic [4:0]  rdst;
      logic        e_req, e_we, e_stall, e_pcsrc, e_rw;
      logic [31:0] e_addr, e_mdata;
   } vec_t;

   always #5 clk_i = ~clk_i;

   mem_access_stage #(.MAX_WAIT(MW)) dut (
      .clk_i(clk_i), .rst_n(rst_n),
      .memread_i(memread_i), .memwrite_i(memwrite_i), .branch_i(branch_i), .zero_i(zero_i),
      .memtoreg_i(memtoreg_i), .RegWrite_i(RegWrite_i), .alu_i(alu_i), .rt_i(rt_i),
      .rd_addr_i(rd_addr_i), .branch_data_i(branch_data_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ready_i(dmem_ready_i),
      .stall_o(stall_o), .pcsrc_o(pcsrc_o), .branch_target_o(branch_target_o),
      .memtoreg_o(memtoreg_o), .RegWrite_o(RegWrite_o), .rd_addr_o(rd_addr_o),
      .alu_o(alu_o), .mem_data_o(mem_data_o), .timeout_o(timeout_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input instr_t t);
      memread_i = t.ld; memwrite_i = t.st; branch_i = t.br; zero_i = t.z;
      memtoreg_i = t.m2r; RegWrite_i = t.rw; alu_i = t.alu; rt_i = t.rt;
      branch_data_i = t.bd; rd_addr_i = t.rdst;
   endtask

   function automatic instr_t rand_instr();
      instr_t t;
      t.ld = 1'($urandom); t.st = 1'($urandom); t.br = 1'($urandom); t.z = 1'($urandom);
      t.m2r = 1'($urandom); t.rw = 1'($urandom);
      t.alu = $urandom; t.rt = $urandom; t.bd = $urandom; t.rdst = 5'($urandom);
      t.lat = $urandom_range(0, MW + 2);
      return t;
   endfunction

   task automatic check_regs_zero(input string tag);
      chk({tag, "_m2r"}, memtoreg_o, 0);
      chk({tag, "_rw"}, RegWrite_o, 0);
      chk({tag, "_rd"}, rd_addr_o, 0);
      chk({tag, "_alu"}, alu_o, 0);
      chk({tag, "_mdata"}, mem_data_o, 0);
      chk({tag, "_timeout"}, timeout_o, 0);
   endtask

   // One instruction: memory answers after t.lat cycles; t.lat > MW never answers.
   task automatic run_instr(input instr_t t, input bit garbage);
      bit acc, abt, done;
      int last;
      logic [31:0] rdata;
      acc  = t.ld | t.st;
      last = !acc ? 0 : (t.lat <= MW ? t.lat : MW);
      abt  = acc && t.lat > MW;
      for (int c = 0; c <= last; c++) begin
         rdata = $urandom;
         if (c == 0) drive(t);
         else if (garbage) drive(rand_instr());
         dmem_rdata_i = rdata;
         dmem_ready_i = acc ? (c == t.lat) : 1'($urandom);
         @(negedge clk_i);
         chk("req", dmem_req_o, acc && !(abt && c == last));
         chk("stall", stall_o, acc && c < last);
         if (acc && !(abt && c == last)) begin
            chk("we", dmem_we_o, t.st);
            chk("addr", dmem_addr_o, t.alu & 32'hFFFF_FFFC);
            chk("wdata", dmem_wdata_o, t.rt);
         end
         chk("pcsrc", pcsrc_o, c == 0 && t.br && t.z);
         chk("target", branch_target_o, branch_data_i);
         @(posedge clk_i); #1;
         done = !acc || (c == last && !abt);
         if (abt && c == last) model_to = 1'b1;
         chk("wb_m2r", memtoreg_o, done ? t.m2r : 1'b0);
         chk("wb_rw", RegWrite_o, done ? t.rw : 1'b0);
         chk("wb_rd", rd_addr_o, done ? t.rdst : 5'd0);
         chk("wb_alu", alu_o, done ? t.alu : 32'd0);
         chk("wb_mdata", mem_data_o, (done && acc && !t.st) ? rdata : 32'd0);
         chk("timeout", timeout_o, model_to);
      end
   endtask

   initial begin
      vec_t   tbl[7];
      instr_t t;
      tbl[0] = '{1,0,0,0,1,1,1, 32'h13,   32'h0,    32'h0,  32'hDEADBEEF, 5'd7,  1,0,0,0,1, 32'h10,   32'hDEADBEEF};
      tbl[1] = '{0,1,0,0,0,0,1, 32'h1007, 32'h55AA, 32'h0,  32'h11111111, 5'd3,  1,1,0,0,0, 32'h1004, 32'h0};
      tbl[2] = '{1,1,0,0,0,0,1, 32'h20,   32'h1234, 32'h0,  32'hCAFEF00D, 5'd9,  1,1,0,0,0, 32'h20,   32'h0};
      tbl[3] = '{0,0,1,1,0,0,0, 32'h8,    32'h0,    32'h40, 32'h22222222, 5'd0,  0,0,0,1,0, 32'h8,    32'h0};
      tbl[4] = '{0,0,1,0,0,0,0, 32'h8,    32'h0,    32'h40, 32'h22222222, 5'd0,  0,0,0,0,0, 32'h8,    32'h0};
      tbl[5] = '{0,0,0,0,0,1,1, 32'hABCD0003, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd31, 0,0,0,0,1, 32'hABCD0000, 32'h0};
      tbl[6] = '{1,0,1,1,1,1,1, 32'h7F,   32'h0,    32'h80, 32'h0BADF00D, 5'd12, 1,0,0,1,1, 32'h7C,   32'h0BADF00D};

      t = '{0,0,0,0,0,0, 0,0,0, 0, 0};
      drive(t);
      dmem_ready_i = 1'b0; dmem_rdata_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_req", dmem_req_o, 0);
      chk("rst_stall", stall_o, 0);
      check_regs_zero("rst");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         memread_i = tbl[i].ld; memwrite_i = tbl[i].st; branch_i = tbl[i].br; zero_i = tbl[i].z;
         memtoreg_i = tbl[i].m2r; RegWrite_i = tbl[i].rw; alu_i = tbl[i].alu; rt_i = tbl[i].rt;
         branch_data_i = tbl[i].bd; rd_addr_i = tbl[i].rdst;
         dmem_rdata_i = tbl[i].rdata; dmem_ready_i = tbl[i].ready;
         @(negedge clk_i);
         chk($sformatf("t%0d_req", i), dmem_req_o, tbl[i].e_req);
         chk($sformatf("t%0d_stall", i), stall_o, tbl[i].e_stall);
         chk($sformatf("t%0d_pcsrc", i), pcsrc_o, tbl[i].e_pcsrc);
         chk($sformatf("t%0d_target", i), branch_target_o, tbl[i].bd);
         chk($sformatf("t%0d_addr", i), dmem_addr_o, tbl[i].e_addr);
         if (tbl[i].e_req) chk($sformatf("t%0d_we", i), dmem_we_o, tbl[i].e_we);
         @(posedge clk_i); #1;
         chk($sformatf("t%0d_mdata", i), mem_data_o, tbl[i].e_mdata);
         chk($sformatf("t%0d_rw", i), RegWrite_o, tbl[i].e_rw);
         chk($sformatf("t%0d_rd", i), rd_addr_o, tbl[i].rdst);
         chk($sformatf("t%0d_alu", i), alu_o, tbl[i].alu);
      end

      // store answered after 3 cycles while the upstream inputs toggle
      t = '{0,1,0,0,0,1, 32'h0000_0104, 32'h55AA, 32'h0, 5'd4, 3};
      run_instr(t, 1'b1);
      // load that is never answered, then a normal load
      chk("pre_timeout", timeout_o, 0);
      t = '{1,0,0,0,1,1, 32'h0000_0200, 32'h0, 32'h0, 5'd6, 100};
      run_instr(t, 1'b1);
      chk("sticky_timeout", timeout_o, 1);
      t = '{1,0,0,0,1,1, 32'h0000_0304, 32'h0, 32'h0, 5'd8, 0};
      run_instr(t, 1'b0);
      chk("timeout_kept", timeout_o, 1);

      // reset during WAIT
      t = '{1,0,0,0,1,1, 32'h0000_0400, 32'h0, 32'h0, 5'd10, 100};
      drive(t);
      dmem_ready_i = 1'b0;
      @(posedge clk_i); #1;
      chk("wait_stall", stall_o, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_req", dmem_req_o, 0);
      chk("arst_stall", stall_o, 0);
      check_regs_zero("arst");
      model_to = 1'b0;
      @(posedge clk_i); #1;
      rst_n = 1'b1;
      t = '{1,0,0,0,1,1, 32'h0000_0508, 32'h0, 32'h0, 5'd11, 2};
      run_instr(t, 1'b1);

      for (int n = 0; n < 400; n++) run_instr(rand_instr(), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage consumer of the EX/MEM pipeline bundle (memread/memwrite/branch/zero/memtoreg/RegWrite, ALU result, rt data, rd address, branch target).
- Drives data memory through a req/ready handshake and holds the pipeline with stall_o while an access is outstanding.
- Resolves taken branches (PCSrc) and registers the MEM/WB bundle consumed by writeback.
- Bounds every memory wait with a timeout.

Parameters:
MAX_WAIT, 15, maximum WAIT-state cycles before an access is aborted (1..255).
ADDR_ALIGN, 2, number of low address bits forced to zero on dmem_addr_o (word alignment).

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
memread_i  in  1  EX/MEM load request
memwrite_i  in  1  EX/MEM store request
branch_i  in  1  EX/MEM branch instruction
zero_i  in  1  EX/MEM ALU zero flag
memtoreg_i  in  1  EX/MEM writeback-select
RegWrite_i  in  1  EX/MEM register-write enable
alu_i  in  32  ALU result / memory address
rt_i  in  32  store data
rd_addr_i  in  5  destination register
branch_data_i  in  32  branch target address
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = write, 0 = read
dmem_addr_o  out  32  aligned address
dmem_wdata_o  out  32  store data
dmem_rdata_i  in  32  load data, valid when dmem_ready_i = 1
dmem_ready_i  in  1  access completes this cycle
stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
pcsrc_o  out  1  take branch
branch_target_o  out  32  branch target address
memtoreg_o  out  1  MEM/WB writeback-select
RegWrite_o  out  1  MEM/WB register-write enable
rd_addr_o  out  5  MEM/WB destination register
alu_o  out  32  MEM/WB ALU result
mem_data_o  out  32  MEM/WB load data
timeout_o  out  1  sticky abort flag

Behaviour:
- Reset (async, any state, including mid-access):
  - FSM to IDLE; wait counter = 0; holding registers = 0.
  - All registered outputs = 0 and timeout_o = 0.
  - dmem_req_o and stall_o fall immediately.
- Access selection: access = memread_i | memwrite_i. If both are set, the access is a write.
- dmem_addr_o = address with its low ADDR_ALIGN bits forced to 0.
- IDLE state:
  - Outputs: dmem_req_o = access; dmem_we_o = memwrite_i; address/wdata taken combinationally from alu_i/rt_i.
  - No access: MEM/WB loads the inputs at the clock edge, with mem_data_o = 0.
  - Access with dmem_ready_i = 1: zero-wait completion.
    - stall_o = 0.
    - MEM/WB loads the inputs; mem_data_o = dmem_rdata_i for a read, 0 for a write.
  - Access with dmem_ready_i = 0:
    - stall_o = 1 combinationally.
    - Capture we/addr/wdata/memtoreg/RegWrite/rd/alu into holding registers.
    - Counter = 1; go to WAIT.
    - MEM/WB loads a bubble: RegWrite_o = 0, memtoreg_o = 0, other fields 0.
- WAIT state:
  - dmem_req_o = 1; dmem_we/addr/wdata driven from the holding registers.
  - stall_o = 1, except in the completion cycle.
  - dmem_ready_i = 1 (completion):
    - stall_o = 0.
    - MEM/WB loads the held bundle; mem_data_o = dmem_rdata_i for a read.
    - Go to IDLE.
  - dmem_ready_i = 0 and counter < MAX_WAIT: counter increments; MEM/WB loads a bubble.
  - dmem_ready_i = 0 and counter = MAX_WAIT (abort):
    - dmem_req_o = 0 and stall_o = 0 that cycle.
    - MEM/WB loads a bubble (the instruction is dropped).
    - timeout_o is set to 1 and stays 1 until reset.
    - Go to IDLE.
- Ready asserted with no request outstanding is ignored.
- Branch resolution:
  - pcsrc_o = branch_i & zero_i & (state == IDLE), combinational.
  - branch_target_o = branch_data_i.
  - Branch and memory access are never set together; if they are, the memory access proceeds and the branch is still taken.
- Latency: MEM/WB updates at the same edge the access completes; a zero-wait access adds no stall cycles; an N-wait access stalls for N cycles.

Decomposition:
- Shared package: FSM state encoding (S_IDLE, S_WAIT), the MEM/WB bundle field widths (REG_ADDR_W = 5, DATA_W = 32), and MAX_WAIT_DEFAULT.
- One sub-module, memwb_reg: the MEM/WB register, with a load port and a bubble input.
- The FSM, counter and holding registers live in the top level.

Test Plan:
- Load from alu_i = 0x0000_0013, dmem_ready_i = 1 in the same cycle, rdata = 0xDEADBEEF:
  - dmem_addr_o = 0x10 and stall_o stays 0.
  - Next edge: mem_data_o = 0xDEADBEEF, RegWrite_o = 1, rd_addr_o as input.
- Store rt_i = 0x55AA, with ready arriving 3 cycles after the request:
  - stall_o is high for exactly 3 cycles; dmem_we_o = 1 and dmem_wdata_o = 0x55AA throughout, even while the inputs toggle.
  - Bubbles (RegWrite_o = 0) are written during the stall.
- Read that never receives ready, with MAX_WAIT = 4:
  - Request is dropped after 4 WAIT cycles; timeout_o = 1 (sticky); MEM/WB is a bubble; the next instruction proceeds normally.
- branch_i = 1, zero_i = 1, branch_data_i = 0x40: pcsrc_o = 1 and branch_target_o = 0x40. With zero_i = 0: pcsrc_o = 0.
- Assert rst_n low during WAIT:
  - dmem_req_o and stall_o fall immediately; all outputs = 0; timeout_o is cleared.
  - After release, a fresh load completes normally.
- memread_i = memwrite_i = 1: dmem_we_o = 1 and mem_data_o = 0 after completion.
